// File: rtl/t07_fpu_issue_if.sv
// Bus between the issuing pipeline/FPU core and the t07_fpu_issue stage.
// Carries the issue request, the core handshake and the write-back beat.
interface t07_fpu_issue_if;
  // Issue side (from operand mux / pipeline)
  logic        issue_i;
  logic [4:0]  FPUOp_i;
  logic [31:0] FPUValA_i;
  logic [31:0] FPUValB_i;
  logic [31:0] FPUValC_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  // Core completion
  logic        fpuDone_i;
  logic [31:0] fpuResult_i;
  logic [4:0]  fpuFlags_i;
  // Launch to core
  logic        fpuStart_o;
  logic [4:0]  fpuOp_o;
  logic [31:0] opA_o;
  logic [31:0] opB_o;
  logic [31:0] opC_o;
  // Pipeline stall and write-back
  logic        busy_o;
  logic        wbValid_o;
  logic [31:0] wbData_o;
  logic [4:0]  wbRd_o;
  logic [4:0]  wbFlags_o;
  logic [4:0]  fflags_o;
  logic        timeout_o;

  modport master (
    output issue_i, FPUOp_i, FPUValA_i, FPUValB_i, FPUValC_i, rd_i, flush_i,
    output fpuDone_i, fpuResult_i, fpuFlags_i,
    input  fpuStart_o, fpuOp_o, opA_o, opB_o, opC_o,
    input  busy_o, wbValid_o, wbData_o, wbRd_o, wbFlags_o, fflags_o, timeout_o
  );

  modport slave (
    input  issue_i, FPUOp_i, FPUValA_i, FPUValB_i, FPUValC_i, rd_i, flush_i,
    input  fpuDone_i, fpuResult_i, fpuFlags_i,
    output fpuStart_o, fpuOp_o, opA_o, opB_o, opC_o,
    output busy_o, wbValid_o, wbData_o, wbRd_o, wbFlags_o, fflags_o, timeout_o
  );
endinterface

// File: rtl/t07_fpu_issue.sv
// FPU operand-capture and sequencing stage. Latches operands on issue, pulses
// the core start, stalls until done, then emits one write-back beat and keeps
// sticky fflags. Optional WAIT watchdog enabled by defining T07_FPU_TIMEOUT_EN.
module t07_fpu_issue #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic           clk,
  input logic           rst,
  t07_fpu_issue_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StWb} state_e;

  state_e      state_q, state_d;
  logic [4:0]  op_q;
  logic [31:0] opa_q, opb_q, opc_q;
  logic [4:0]  rd_q;
  logic [31:0] res_q;
  logic [4:0]  flags_q;
  logic [4:0]  fflags_q;
  logic        accept;
  logic        done_ok;
  logic        abort;

  assign accept  = (state_q == StIdle) && bus.issue_i && !bus.flush_i;
  // Done only counts while the core is actually running an op.
  assign done_ok = bus.fpuDone_i && !bus.flush_i &&
                   ((state_q == StLaunch) || (state_q == StWait));

`ifdef T07_FPU_TIMEOUT_EN
  logic [7:0] wait_cnt_q;
  logic       timeout_q;

  // Abort on the cycle the count of done-less WAIT cycles would hit the limit.
  assign abort = (state_q == StWait) && !bus.fpuDone_i && !bus.flush_i &&
                 (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));

  // WAIT cycle counter, cleared outside WAIT so it restarts on every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= abort;
      if (state_q != StWait) begin
        wait_cnt_q <= 8'd0;
      end else if (!bus.fpuDone_i) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
    end
  end
`else
  logic timeout_q;
  assign abort     = 1'b0;
  assign timeout_q = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StLaunch;
      StLaunch: state_d = bus.fpuDone_i ? StWb : StWait;
      StWait:   if (bus.fpuDone_i || abort) state_d = StWb;
      StWb:     state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (bus.flush_i) state_d = StIdle;
  end

  // Operand, result and sticky-flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= 5'd0;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      opc_q    <= 32'd0;
      rd_q     <= 5'd0;
      res_q    <= 32'd0;
      flags_q  <= 5'd0;
      fflags_q <= 5'd0;
    end else begin
      if (accept) begin
        op_q  <= bus.FPUOp_i;
        opa_q <= bus.FPUValA_i;
        opb_q <= bus.FPUValB_i;
        opc_q <= bus.FPUValC_i;
        rd_q  <= bus.rd_i;
      end
      if (done_ok) begin
        res_q   <= bus.fpuResult_i;
        flags_q <= bus.fpuFlags_i;
      end else if (abort) begin
        res_q   <= 32'h7FC0_0000;  // canonical quiet NaN
        flags_q <= 5'b10000;       // NV
      end
      if ((state_q == StWb) && !bus.flush_i) begin
        fflags_q <= fflags_q | flags_q;
      end
    end
  end

  // Outputs decoded from state and held registers.
  always_comb begin
    bus.fpuStart_o = (state_q == StLaunch);
    bus.busy_o     = (state_q != StIdle);
    bus.wbValid_o  = (state_q == StWb) && !bus.flush_i;
    bus.timeout_o  = timeout_q;
    bus.fpuOp_o    = op_q;
    bus.opA_o      = opa_q;
    bus.opB_o      = opb_q;
    bus.opC_o      = opc_q;
    bus.wbData_o   = res_q;
    bus.wbRd_o     = rd_q;
    bus.wbFlags_o  = flags_q;
    bus.fflags_o   = fflags_q;
  end

endmodule

// File: doc/t07_fpu_issue.md
# t07_fpu_issue

Operand-capture and sequencing stage between the FPU operand mux and the FPU datapath core. It latches the mux's selected operands (A/B/C), opcode and destination register on an issue request and launches the core with a one-cycle start pulse. It holds the pipeline stalled until the core reports done, then presents one write-back beat with result and exception flags, and accumulates sticky fflags.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before forced abort (used only with T07_FPU_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_i  in  1  request to start an FPU op this cycle.
- FPUOp_i  in  5  operation code (0–3 fused multiply-add family, 21/22 int-to-float, others two-operand).
- FPUValA_i, FPUValB_i, FPUValC_i  in  32 each  operands from the FPU operand mux.
- rd_i  in  5  destination register index.
- flush_i  in  1  abort any in-flight op.
- fpuDone_i  in  1  core completion strobe.
- fpuResult_i  in  32  core result, valid with fpuDone_i.
- fpuFlags_i  in  5  core flags {NV,DZ,OF,UF,NX}, valid with fpuDone_i.
- fpuStart_o  out  1  one-cycle launch pulse to core.
- fpuOp_o  out  5  latched opcode.
- opA_o, opB_o, opC_o  out  32 each  latched operands.
- busy_o  out  1  stall to the issuing pipeline.
- wbValid_o  out  1  one-cycle write-back strobe.
- wbData_o  out  32  write-back value.
- wbRd_o  out  5  write-back destination.
- wbFlags_o  out  5  flags of this write-back.
- fflags_o  out  5  sticky OR of all written-back flags.
- timeout_o  out  1  one-cycle pulse on forced abort.

## Operation
- States: IDLE, LAUNCH, WAIT, WB.
- IDLE: busy_o=0. If issue_i=1 and flush_i=0: latch FPUOp_i, FPUVal{A,B,C}_i, rd_i; next LAUNCH. issue_i while not IDLE is ignored (issuer must honour busy_o).
- LAUNCH: fpuStart_o=1 for exactly this cycle. If fpuDone_i=1 this cycle, capture result/flags, next WB; else next WAIT.
- WAIT: on fpuDone_i=1, capture fpuResult_i/fpuFlags_i, next WB.
- WB: wbValid_o=1, wbData_o/wbFlags_o = captured values, wbRd_o = latched rd; fflags_o |= wbFlags_o at the clock edge; next IDLE.
- busy_o = (state != IDLE), combinational from state.
- opA/B/C_o, fpuOp_o hold latched values from capture until next capture.
- flush_i=1 in any state: next IDLE, no wbValid_o, fflags_o unchanged; fpuDone_i arriving in the same cycle is discarded. flush_i in WB suppresses that cycle's wbValid_o and the fflags_o update.
- fpuDone_i while in IDLE or WB is ignored.
- Opcode is not decoded; operand C is passed through as supplied by the mux (zero for non-FMA ops).

## Timing
- Reset (rst=1 at edge): state IDLE; all outputs 0, including opA/B/C_o, fpuOp_o, wbData_o, wbRd_o, wbFlags_o and fflags_o.
- Issue accepted at edge N. fpuStart_o=1 during cycle N+1.
- Done seen in cycle M ≥ N+1. wbValid_o=1 during cycle M+1. busy_o drops in cycle M+2.
- Minimum issue-to-write-back is 2 cycles (done in the LAUNCH cycle). A new issue is accepted at the earliest in cycle M+2.
- busy_o is high in the cycle after acceptance; the issuer keeps its stage frozen from then.

## Configuration
- T07_FPU_TIMEOUT_EN defined:
  - An 8-bit WAIT counter clears on entry to WAIT and increments each WAIT cycle without done.
  - On reaching TIMEOUT_CYCLES: next WB with wbData_o=32'h7FC00000, wbFlags_o=5'b10000 (NV), timeout_o=1 in that WB cycle.
  - A late fpuDone_i after the abort is ignored.
- Not defined: no counter; WAIT persists until done or flush; timeout_o tied 0.

## Test plan
- Reset: hold rst 2 cycles → all outputs 0, busy_o=0.
- Basic add: issue op=5'd4, A=32'h3F800000, B=32'h40000000, rd=7; done after 3 WAIT cycles with result 32'h40400000, flags 0 → fpuStart_o in cycle 1 only; wbValid_o one cycle with data 32'h40400000, rd 7; busy_o high for exactly 5 cycles.
- Done in LAUNCH with FMA op=0, C=32'h3F800000 → opC_o=32'h3F800000; wbValid_o the following cycle; back-to-back issue accepted 2 cycles later.
- Sticky flags: two ops return flags 5'b00001 then 5'b01000 → fflags_o=5'b01001 after the second WB; reset clears it to 0.
- Flush in WAIT with simultaneous fpuDone_i → no wbValid_o, fflags_o unchanged, IDLE next cycle.
- T07_FPU_TIMEOUT_EN with TIMEOUT_CYCLES=4, done never asserted → WB 4 WAIT cycles after entry with data 32'h7FC00000, flags 5'b10000, timeout_o=1; a later done is ignored.
